ysyx_24080014_lsu: RTL and testbench

- Multi-cycle load/store unit between EXU and a valid/ready memory port; replaces the single-cycle, zero-extend-only memory access stage.
- Adds parametrised data width, byte-lane alignment and write strobes, sign/zero extension, misalignment detection, handshakes on both sides and error reporting.
- One transaction in flight; EXU stalls on in_ready.

---
 rtl/ysyx_24080014_lsu.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu - multi-cycle load/store unit between EXU and a
// valid/ready memory port. One transaction in flight; EXU stalls on in_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      EXU request handshake
//   in_is_load, in_is_store  operation select (exactly one must be set)
//   in_funct3                RISC-V funct3 (size in [1:0], unsigned in [2])
//   in_addr, in_wdata        byte address, LSB-justified store data
//   out_valid / out_ready    result handshake towards WBU
//   out_rdata                extended load data (0 for stores / error paths)
//   out_err                  00 ok, 01 misaligned, 10 bus error/timeout, 11 illegal
//   mem_req_*                bus request: word-aligned addr, lane data, strobes
//   mem_resp_*               bus response: full-word data and error flag
//
// Optional feature: define YSYX_24080014_LSU_TIMEOUT_EN to abort a bus
// transaction after TIMEOUT_CYC cycles in REQ/WAIT with err 10. Without the
// macro the unit waits on the bus indefinitely.
module ysyx_24080014_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rdata,
  output logic [1:0]            out_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_resp_rdata,
  input  logic                  mem_resp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Latched request context needed after acceptance.
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;

  // Request decode (combinational on the EXU inputs).
  logic              req_illegal;
  logic              req_misalign;
  logic [OFF_W-1:0]  in_off;
  logic [STRB_W-1:0] size_mask;

  // Load extraction.
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_ext;

  // Handshake / event strobes.
  logic accept;
  logic resp_fire;
  logic to_fire;

  assign in_off    = in_addr[OFF_W-1:0];
  assign accept    = (state == S_IDLE) && in_valid;
  assign resp_fire = (state == S_WAIT) && mem_resp_valid;

  always_comb begin
    req_illegal = (in_is_load == in_is_store);
    if ((DATA_W == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)))
      req_illegal = 1'b1;
    if (in_is_load && (in_funct3 == 3'b111))
      req_illegal = 1'b1;
    if (in_is_store && in_funct3[2])
      req_illegal = 1'b1;

    unique case (in_funct3[1:0])
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = in_addr[0];
      2'b10:   req_misalign = (in_addr[1:0] != 2'b00);
      default: req_misalign = (in_addr[2:0] != 3'b000);
    endcase

    unique case (in_funct3[1:0])
      2'b00:   size_mask = STRB_W'(1);
      2'b01:   size_mask = STRB_W'(3);
      2'b10:   size_mask = STRB_W'(15);
      default: size_mask = '1;
    endcase
  end

  always_comb begin
    lane     = mem_resp_rdata >> {r_off, 3'b000};
    load_ext = lane;
    unique case (r_funct3)
      3'b000:  load_ext = DATA_W'($signed(lane[7:0]));
      3'b001:  load_ext = DATA_W'($signed(lane[15:0]));
      3'b010:  load_ext = DATA_W'($signed(lane[31:0]));
      3'b100:  load_ext = DATA_W'(lane[7:0]);
      3'b101:  load_ext = DATA_W'(lane[15:0]);
      3'b110:  load_ext = DATA_W'(lane[31:0]);
      default: load_ext = lane;
    endcase
  end

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if ((state == S_REQ) || (state == S_WAIT))
      to_cnt <= to_cnt + TO_W'(1);
  end

  // A handshake on the last allowed cycle still wins over the timeout so
  // the FSM and the result registers always agree on the outcome.
  assign to_fire = (((state == S_REQ)  && !mem_req_ready) ||
                    ((state == S_WAIT) && !mem_resp_valid)) &&
                   (to_cnt >= TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    out_valid      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready       = 1'b1;
        mem_resp_ready = 1'b1;  // stray responses are swallowed here
        if (in_valid)
          state_nxt = (req_illegal || req_misalign) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_nxt = S_WAIT;
        else if (to_fire)
          state_nxt = S_RESP;
      end
      S_WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid || to_fire)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_load     <= 1'b0;
      r_funct3      <= '0;
      r_off         <= '0;
      out_rdata     <= '0;
      out_err       <= 2'b00;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      if (accept) begin
        r_is_load <= in_is_load;
        r_funct3  <= in_funct3;
        r_off     <= in_off;
        if (req_illegal) begin
          out_err   <= 2'b11;
          out_rdata <= '0;
        end else if (req_misalign) begin
          out_err   <= 2'b01;
          out_rdata <= '0;
        end else begin
          mem_req_wen   <= in_is_store;
          mem_req_addr  <= in_addr & ~ADDR_W'(STRB_W - 1);
          mem_req_wdata <= in_is_store ? (in_wdata << {in_off, 3'b000}) : '0;
          mem_req_wstrb <= in_is_store ? (size_mask << in_off) : '0;
        end
      end
      if (resp_fire) begin
        out_rdata <= r_is_load ? load_ext : '0;
        out_err   <= mem_resp_err ? 2'b10 : 2'b00;
      end else if (to_fire) begin
        out_rdata <= '0;
        out_err   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  int checks = 0;
  int errors = 0;

  ysyx_24080014_lsu #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: what the LSU must report for one request.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rdata,
                                input logic rerr, output logic [1:0] e_err,
                                output logic [31:0] e_rdata, output logic [31:0] e_addr,
                                output logic [3:0] e_wstrb);
    int    size;
    int    off;
    bit    ill;
    longint v;
    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    ill  = (ld == st) || (f3 == 3) || (f3 == 6) || (ld && f3 == 7) || (st && f3 >= 4);
    if (ill)                    e_err = 2'b11;
    else if (addr % size != 0)  e_err = 2'b01;
    else if (rerr)              e_err = 2'b10;
    else                        e_err = 2'b00;
    e_addr  = addr - off;
    e_wstrb = st ? 4'(((1 << size) - 1) << off) : 4'h0;
    e_rdata = 32'h0;
    if (ld) begin
      v = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      if (f3 < 4 && ((v >> (8 * size - 1)) & 1) == 1)
        v = v - (longint'(1) << (8 * size));
      e_rdata = v[31:0];
    end
  endfunction

  // Drives one EXU request from a negedge and plays the bus and WBU sides.
  // resp_dly < 0 means the response is presented together with mem_req_ready.
  // Returns at the negedge after the output handshake.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic rerr,
                         input int req_dly, input int resp_dly, input int out_dly,
                         output int lat, output int hs, output logic [31:0] q_addr,
                         output logic [31:0] q_wdata, output logic [3:0] q_wstrb,
                         output logic q_wen, output logic [31:0] r_data,
                         output logic [1:0] r_err, output bit stable, output bit idle_ok);
    int rq_wait = 0, rs_cnt = 0, o_wait = 0;
    bit req_pend = 0, req_done = 0, resp_pend = 0, resp_done = 0;
    bit rq_seen = 0, out_seen = 0, out_pend = 0;
    lat = -1; hs = 0; stable = 1; idle_ok = 0;
    q_addr = '0; q_wdata = '0; q_wstrb = '0; q_wen = 0; r_data = '0; r_err = '0;
    in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
    for (int c = 1; c <= 80 + req_dly + out_dly; c++) begin
      if (req_pend) begin
        hs++; req_done = 1; req_pend = 0; mem_req_ready = 0;
      end
      if (resp_pend) begin
        resp_done = 1; resp_pend = 0; mem_resp_valid = 0;
      end
      if (out_pend) begin
        out_ready = 0;
        idle_ok = (in_ready === 1'b1) && (out_valid === 1'b0) && (mem_req_valid === 1'b0);
        break;
      end
      if (in_ready !== 1'b0) stable = 0;
      if (mem_req_valid === 1'b1) begin
        if (!rq_seen) begin
          rq_seen = 1; q_addr = mem_req_addr; q_wdata = mem_req_wdata;
          q_wstrb = mem_req_wstrb; q_wen = mem_req_wen;
        end else if (mem_req_addr !== q_addr || mem_req_wdata !== q_wdata ||
                     mem_req_wstrb !== q_wstrb || mem_req_wen !== q_wen) begin
          stable = 0;
        end
        if (rq_wait >= req_dly) begin
          mem_req_ready = 1; req_pend = 1;
          if (resp_dly < 0 && !req_done) begin
            mem_resp_valid = 1; mem_resp_rdata = rdata; mem_resp_err = rerr;
          end
        end else begin
          rq_wait++;
        end
      end
      if (req_done && !resp_done && !mem_resp_valid) begin
        if (rs_cnt >= resp_dly) begin
          mem_resp_valid = 1; mem_resp_rdata = rdata; mem_resp_err = rerr;
        end else begin
          rs_cnt++;
        end
      end
      if (mem_resp_valid && mem_resp_ready === 1'b1) resp_pend = 1;
      if (out_valid === 1'b1) begin
        if (!out_seen) begin
          out_seen = 1; lat = c; r_data = out_rdata; r_err = out_err;
        end else if (out_rdata !== r_data || out_err !== r_err) begin
          stable = 0;
        end
        if (o_wait >= out_dly) begin
          out_ready = 1; out_pend = 1;
        end else begin
          o_wait++;
        end
      end
      @(negedge clk);
    end
    mem_req_ready = 0; mem_resp_valid = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, mem_req_valid, mem_resp_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_handshakes: got %b required 1001",
               {in_ready, out_valid, mem_req_valid, mem_resp_ready});
    end
    checks++;
    if (out_rdata !== 32'h0 || out_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: got rdata=%h err=%b required 0/00", out_rdata, out_err);
    end
    checks++;
    if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wstrb !== 4'h0 ||
        mem_req_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_regs: got addr=%h wdata=%h wstrb=%b wen=%b required zeros",
               mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen);
    end
  endtask

  task automatic test_lb_sign();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(1, 0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d required 3", lat); end
    checks++;
    if (rd !== 32'hFFFFFF80 || re !== 2'b00) begin
      errors++; $display("FAIL lb_data: got %h/%b required ffffff80/00", rd, re);
    end
    checks++;
    if (qa !== 32'h80000000 || qs !== 4'b0000 || qw !== 1'b0 || hs !== 1) begin
      errors++;
      $display("FAIL lb_req: got addr=%h wstrb=%b wen=%b hs=%0d required 80000000/0000/0/1",
               qa, qs, qw, hs);
    end
    checks++;
    if (!idl) begin errors++; $display("FAIL lb_idle_after: got busy required idle"); end
  endtask

  task automatic test_sh_lane();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 32'h12345678, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (qw !== 1'b1 || qs !== 4'b1100 || qd !== 32'hBEEF0000 || qa !== 32'h80000000) begin
      errors++;
      $display("FAIL sh_req: got wen=%b wstrb=%b wdata=%h addr=%h required 1/1100/beef0000/80000000",
               qw, qs, qd, qa);
    end
    checks++;
    if (rd !== 32'h0 || re !== 2'b00 || lat !== 3) begin
      errors++; $display("FAIL sh_out: got rdata=%h err=%b lat=%0d required 0/00/3", rd, re, lat);
    end
  endtask

  task automatic test_error_paths();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(1, 0, 3'b010, 32'h80000001, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b01 || lat !== 1 || hs !== 0) begin
      errors++; $display("FAIL misaligned_lw: got err=%b lat=%0d hs=%0d required 01/1/0", re, lat, hs);
    end
    run_txn(1, 1, 3'b010, 32'h80000000, 32'h0, 32'h0, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b11 || lat !== 1 || hs !== 0) begin
      errors++; $display("FAIL illegal_both: got err=%b lat=%0d hs=%0d required 11/1/0", re, lat, hs);
    end
    run_txn(1, 0, 3'b111, 32'h80000000, 32'h0, 32'h0, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b11 || lat !== 1 || !idl) begin
      errors++; $display("FAIL illegal_f3_111: got err=%b lat=%0d required 11/1", re, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(1, 0, 3'b010, 32'h80000004, 32'h0, 32'hCAFEF00D, 0, 5, 2, 3,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (!stb || hs !== 1) begin
      errors++; $display("FAIL backpressure_stable: got stable=%0d hs=%0d required 1/1", stb, hs);
    end
    checks++;
    if (lat !== 10 || rd !== 32'hCAFEF00D || re !== 2'b00 || !idl) begin
      errors++;
      $display("FAIL backpressure_result: got lat=%0d rdata=%h err=%b required 10/cafef00d/00",
               lat, rd, re);
    end
  endtask

  task automatic test_bus_error_and_early_resp();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(1, 0, 3'b001, 32'h80000002, 32'h0, 32'h12345678, 1, 0, 1, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b10 || lat !== 4) begin
      errors++; $display("FAIL bus_error: got err=%b lat=%0d required 10/4", re, lat);
    end
    run_txn(1, 0, 3'b101, 32'h80000002, 32'h0, 32'h8001ABCD, 0, 0, -1, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b00 || lat !== 3 || rd !== 32'h00008001) begin
      errors++;
      $display("FAIL early_resp_lhu: got err=%b lat=%0d rdata=%h required 00/3/00008001", re, lat, rd);
    end
  endtask

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
  task automatic test_timeout();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    run_txn(1, 0, 3'b010, 32'h80000008, 32'h0, 32'h0, 0, 0, 1000, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (re !== 2'b10 || lat !== 5) begin
      errors++; $display("FAIL timeout: got err=%b lat=%0d required 10/5", re, lat);
    end
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF; mem_resp_err = 0;
    @(negedge clk);
    mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_resp_ignored: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'b010; in_addr = 32'h80000010;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({in_ready, out_valid, mem_req_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_in_wait: got in_ready/out_valid/req_valid=%b required 100",
               {in_ready, out_valid, mem_req_valid});
    end
    run_txn(1, 0, 3'b100, 32'h80000000, 32'h0, 32'h000000F0, 0, 0, 0, 0,
            lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
    checks++;
    if (rd !== 32'h000000F0 || re !== 2'b00 || lat !== 3) begin
      errors++;
      $display("FAIL lbu_after_reset: got rdata=%h err=%b lat=%0d required 000000f0/00/3", rd, re, lat);
    end
  endtask

  task automatic test_random();
    int lat, hs; logic [31:0] qa, qd, rd; logic [3:0] qs; logic qw; logic [1:0] re; bit stb, idl;
    logic ld, st, rerr; logic [2:0] f3; logic [31:0] addr, wdata, rdata, sh;
    logic [1:0] e_err; logic [31:0] e_rdata, e_addr; logic [3:0] e_wstrb;
    int rq, rs, od, e_lat; bit bad;
    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0) ? ld : ~ld;
      f3 = 3'($urandom);
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      rerr = ($urandom_range(0, 7) == 0);
      rq = $urandom_range(0, 3); rs = int'($urandom_range(0, 4)) - 1; od = $urandom_range(0, 3);
      model(ld, st, f3, addr, rdata, rerr, e_err, e_rdata, e_addr, e_wstrb);
      e_lat = (e_err == 2'b01 || e_err == 2'b11) ? 1 : 3 + rq + ((rs < 0) ? 0 : rs);
      run_txn(ld, st, f3, addr, wdata, rdata, rerr, rq, rs, od,
              lat, hs, qa, qd, qs, qw, rd, re, stb, idl);
      checks++;
      if (re !== e_err || lat !== e_lat || !stb || !idl) begin
        errors++;
        $display("FAIL rand_%0d_status: got err=%b lat=%0d stable=%0d idle=%0d required %b/%0d/1/1 (ld=%b st=%b f3=%b addr=%h)",
                 n, re, lat, stb, idl, e_err, e_lat, ld, st, f3, addr);
      end
      if (e_err == 2'b00) begin
        checks++;
        if (rd !== e_rdata) begin
          errors++; $display("FAIL rand_%0d_rdata: got %h required %h", n, rd, e_rdata);
        end
      end
      if (e_err == 2'b00 || e_err == 2'b10) begin
        sh = wdata << (8 * (addr % 4));
        bad = 0;
        for (int b = 0; b < 4; b++)
          if (e_wstrb[b] && qd[8*b +: 8] !== sh[8*b +: 8]) bad = 1;
        checks++;
        if (bad || qa !== e_addr || qs !== e_wstrb || qw !== st || hs !== 1) begin
          errors++;
          $display("FAIL rand_%0d_req: got addr=%h wstrb=%b wen=%b wdata=%h hs=%0d required %h/%b/%b/%h(lanes)/1",
                   n, qa, qs, qw, qd, hs, e_addr, e_wstrb, st, sh);
        end
      end else begin
        checks++;
        if (hs !== 0) begin
          errors++; $display("FAIL rand_%0d_no_req: got %0d bus requests required 0", n, hs);
        end
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = '0;
    in_addr = '0; in_wdata = '0; out_ready = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
    @(negedge clk);
    test_reset();
    test_lb_sign();
    test_sh_lane();
    test_error_paths();
    test_backpressure();
    test_bus_error_and_early_resp();
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
